multicycle_main_ctrl: RTL and testbench

//  Main control FSM of the multicycle datapath; produces ALUOp[1:0] consumed by the ALU-control decoder
//  (00 add: address/PC, 01 sub: branch compare, 10 use funct field). Sequences fetch/decode/execute/

---
 rtl/multicycle_main_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_main_ctrl
// Description : Main control FSM of a multicycle datapath. Sequences
//               fetch/decode/execute/memory/writeback per opcode, stalls on
//               the memory handshake, traps illegal opcodes and memory
//               timeouts into a sticky HALT state.
//               Optional feature macro: MCTRL_ADDI_EN (adds the addi path).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_main_ctrl #(
    parameter int MEM_TIMEOUT = 16,   // max wait cycles in one memory state (>=2)
    parameter int CNT_W       = 5     // wait counter width, must hold MEM_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       err
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RCOMP   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_START   = 4'd14,
        S_HALT    = 4'd15
`ifdef MCTRL_ADDI_EN
        ,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
`ifdef MCTRL_ADDI_EN
    localparam logic [5:0] c_op_addi  = 6'b001000;
`endif

    // Last count value tolerated while waiting; one more idle cycle traps.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Timeout fires only when the memory is still idle on the last allowed count.
    logic w_timeout;
    assign w_timeout = !mem_ready && (r_cnt == c_cnt_last);

    // State register, memory wait counter and sticky trap flag.
    // The counter is cleared on every cycle that is not a memory wait, so it
    // is always zero on entry to FETCH/MEMRD/MEMWR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cnt <= '0;
            case (r_state)
                S_START:  r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        c_op_rtype:         r_state <= S_EXEC;
                        c_op_lw, c_op_sw:   r_state <= S_MEMADR;
                        c_op_beq:           r_state <= S_BRANCH;
                        c_op_j:             r_state <= S_JUMP;
`ifdef MCTRL_ADDI_EN
                        c_op_addi:          r_state <= S_ADDI_EX;
`endif
                        default: begin
                            r_state <= S_HALT;
                            r_err   <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    // Opcode is re-sampled here; anything but lw/sw is illegal.
                    if (opcode == c_op_lw) begin
                        r_state <= S_MEMRD;
                    end else if (opcode == c_op_sw) begin
                        r_state <= S_MEMWR;
                    end else begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        r_state <= S_MEMWB;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_MEMWB:  r_state <= S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) begin
                        r_state <= S_FETCH;
                    end else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_EXEC:   r_state <= S_RCOMP;
                S_RCOMP:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JUMP:   r_state <= S_FETCH;
`ifdef MCTRL_ADDI_EN
                S_ADDI_EX: r_state <= S_ADDI_WB;
                S_ADDI_WB: r_state <= S_FETCH;
`endif
                S_HALT:   r_state <= S_HALT;
                default: begin
                    // Unused encodings are treated as a trap.
                    r_state <= S_HALT;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    // Control decode from the current state; FETCH strobes follow mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RCOMP: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`ifdef MCTRL_ADDI_EN
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = r_state;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_main_ctrl
// Description : Self-checking bench for multicycle_main_ctrl. An
//               instruction-level reference model expands each opcode and
//               memory-delay choice into the expected state trace; each
//               state maps to its expected control word.
//               Honours MCTRL_ADDI_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_ctrl;

    localparam int MEM_TIMEOUT = 16;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int q_st[$];
    bit q_mr[$];

    multicycle_main_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .state(state), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word in a fixed field order.
    function automatic logic [31:0] dut_ctrl();
        return {15'b0, pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source};
    endfunction

    // Expected control word for a given state, straight from the state table.
    function automatic logic [31:0] model_ctrl(int s, bit mr, bit z);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  begin sb = 2'b11; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin sa = 1; sb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {15'b0, pw, pwc, pw | (pwc & z), iod, mrd, mwr, irw, m2r, rdst, rw, sa,
                sb, aop, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, check every output, advance to the next low phase.
    task automatic step(input int est, input bit mr, input bit z, input logic [5:0] op);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        #1;
        chk("state", 32'(state), 32'(est));
        chk("ctrl",  dut_ctrl(), model_ctrl(est, mr, z));
        chk("err",   32'(err),   32'(est == 15));
        cyc++;
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle: outputs clear at once, START for one cycle.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'($urandom);
        #1;
        chk("rst_state", 32'(state), 32'd14);
        chk("rst_ctrl",  dut_ctrl(), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(14, 1'($urandom), 1'($urandom), 6'($urandom));
    endtask

    function automatic void push(int s, bit m);
        q_st.push_back(s);
        q_mr.push_back(m);
    endfunction

    // Memory wait of d idle cycles; returns 1 when the wait runs into the trap.
    function automatic bit push_wait(int s, int d);
        for (int i = 0; i < d && i < MEM_TIMEOUT; i++) push(s, 1'b0);
        if (d >= MEM_TIMEOUT) begin
            push(15, 1'($urandom));
            return 1'b1;
        end
        push(s, 1'b1);
        return 1'b0;
    endfunction

    // Expand one instruction into its expected trace and run it.
    task automatic run_instr(input logic [5:0] op, input bit z, input int df, input int dm);
        bit halted;
        q_st.delete();
        q_mr.delete();
        halted = push_wait(0, df);
        if (!halted) begin
            push(1, 1'($urandom));
            case (op)
                OP_R:   begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
                OP_LW:  begin
                    push(2, 1'($urandom));
                    halted = push_wait(3, dm);
                    if (!halted) push(4, 1'($urandom));
                end
                OP_SW:  begin push(2, 1'($urandom)); halted = push_wait(5, dm); end
                OP_BEQ: push(8, 1'($urandom));
                OP_J:   push(9, 1'($urandom));
`ifdef MCTRL_ADDI_EN
                OP_ADDI: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
`endif
                default: begin push(15, 1'($urandom)); halted = 1'b1; end
            endcase
        end
        if (halted) begin
            push(15, 1'($urandom));
            push(15, 1'($urandom));
        end
        foreach (q_st[i]) begin
            if (q_st[i] == 1 || q_st[i] == 2) step(q_st[i], q_mr[i], z, op);
            else                              step(q_st[i], q_mr[i], z, 6'($urandom));
        end
        if (halted) do_reset();
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(14, 16));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] op;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Directed cases
        run_instr(OP_R,    1'b0, 0, 0);
        run_instr(OP_LW,   1'b1, 0, 3);
        run_instr(OP_SW,   1'b0, 1, 2);
        run_instr(OP_BEQ,  1'b1, 0, 0);
        run_instr(OP_BEQ,  1'b0, 0, 0);
        run_instr(OP_J,    1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b1, 0, 0);
        run_instr(OP_R,    1'b0, MEM_TIMEOUT - 1, 0);
        run_instr(OP_R,    1'b0, MEM_TIMEOUT, 0);
        run_instr(OP_LW,   1'b0, 0, MEM_TIMEOUT - 1);
        run_instr(OP_SW,   1'b0, 0, MEM_TIMEOUT);
        run_instr(OP_BAD,  1'b0, 0, 0);

        // Reset in the middle of a load's memory wait
        step(0, 1'b1, 1'b0, 6'($urandom));
        step(1, 1'b0, 1'b0, OP_LW);
        step(2, 1'b1, 1'b0, OP_LW);
        step(3, 1'b0, 1'b0, OP_LW);
        step(3, 1'b0, 1'b0, OP_LW);
        do_reset();
        run_instr(OP_LW, 1'b0, 0, 0);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 7))
                0:       op = OP_R;
                1, 6:    op = OP_LW;
                2:       op = OP_SW;
                3:       op = OP_BEQ;
                4:       op = OP_J;
                5:       op = OP_ADDI;
                default: op = 6'($urandom);
            endcase
            run_instr(op, 1'($urandom), rand_delay(), rand_delay());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
